// File: rtl/dpsk_pkg.sv
// Shared constants and state encoding for the DPSK carrier path
// (sequencer, cosine ROM and bench).
package dpsk_pkg;
  localparam int SAMPLES_PER_CYC = 20;
  localparam int PI_OFFSET       = 10;
  localparam int IDX_W           = 5;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/dpsk_phase_add.sv
// Registered carrier phase: (samp_cnt + offset) mod 20 via compare-and-subtract.
module dpsk_phase_add
  import dpsk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [IDX_W-1:0] samp_cnt,
  input  logic [IDX_W-1:0] offset,
  output logic [IDX_W-1:0] phase_idx
);
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] wrapped;

  // Both operands are below 20, so the sum tops out at 29.
  // A single subtract therefore covers the wrap.
  always_comb begin
    sum     = {1'b0, samp_cnt} + {1'b0, offset};
    wrapped = sum[IDX_W-1:0];
    if (sum >= (IDX_W+1)'(SAMPLES_PER_CYC))
      wrapped = IDX_W'(sum - (IDX_W+1)'(SAMPLES_PER_CYC));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) phase_idx <= '0;
    else if (ld)    phase_idx <= wrapped;
  end
endmodule

// File: rtl/dpsk_carrier_sequencer.sv
// DPSK carrier sequencer: differential bit encoder, sample/cycle counters and
// the IDLE/RUN handshake FSM feeding phase indices to the cosine ROM.
module dpsk_carrier_sequencer
  import dpsk_pkg::*;
#(
  parameter int CYC_PER_SYM = 4,
  parameter int CYC_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [IDX_W-1:0] phase_idx,
  output logic             sample_valid,
  output logic             diff_bit,
  output logic             sym_start,
  output logic             busy,
  output logic             underrun,
  input  logic             clr_underrun
);
  state_t           state, state_nx;
  logic [IDX_W-1:0] samp_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [IDX_W-1:0] offset;
  logic             prev_d, d_new, xfer, samp_wrap, cyc_last, sym_end, step;

  assign step      = (state == RUN) && en;
  assign samp_wrap = (samp_cnt == IDX_W'(SAMPLES_PER_CYC - 1));
  assign cyc_last  = (cyc_cnt == CYC_W'(CYC_PER_SYM - 1));
  assign sym_end   = step && samp_wrap && cyc_last;
  assign xfer      = bit_valid && bit_ready;
  assign d_new     = bit_in ^ prev_d;
  assign busy      = (state == RUN);
  // diff_bit always equals the encoded bit of the symbol being sampled.
  assign offset    = diff_bit ? IDX_W'(PI_OFFSET) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    bit_ready = 1'b0;
    case (state)
      IDLE: begin
        bit_ready = 1'b1;
        if (bit_valid) state_nx = RUN;
      end
      RUN: begin
        if (sym_end) begin
          bit_ready = 1'b1;
          if (!bit_valid) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt     <= '0;
      cyc_cnt      <= '0;
      prev_d       <= 1'b0;
      diff_bit     <= 1'b0;
      sample_valid <= 1'b0;
      sym_start    <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      sample_valid <= step;
      sym_start    <= step && (samp_cnt == '0) && (cyc_cnt == '0);
      if (xfer) begin
        prev_d   <= d_new;
        diff_bit <= d_new;
        samp_cnt <= '0;
        cyc_cnt  <= '0;
      end else if (step) begin
        if (samp_wrap) begin
          samp_cnt <= '0;
          cyc_cnt  <= cyc_last ? '0 : cyc_cnt + 1'b1;
        end else begin
          samp_cnt <= samp_cnt + 1'b1;
        end
      end
      // A missed symbol end outranks a same-cycle clear.
      if (sym_end && !xfer) underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
    end
  end

  dpsk_phase_add u_phase (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == IDLE),
    .ld       (step),
    .samp_cnt (samp_cnt),
    .offset   (offset),
    .phase_idx(phase_idx)
  );
endmodule

// File: tb/tb_dpsk_carrier_sequencer.sv
// Scoreboard bench: each accepted bit queues its whole symbol of expected
// samples; a negedge monitor pops and compares whenever sample_valid is high.
module tb_dpsk_carrier_sequencer;
  import dpsk_pkg::*;

  localparam int CPS = 4;
  localparam int SYM_LEN = CPS * SAMPLES_PER_CYC;

  logic             clk = 1'b0;
  logic             rst, en, bit_in, bit_valid, clr_underrun;
  logic             bit_ready, sample_valid, diff_bit, sym_start, busy, underrun;
  logic [IDX_W-1:0] phase_idx;

  dpsk_carrier_sequencer #(.CYC_PER_SYM(CPS), .CYC_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .phase_idx(phase_idx), .sample_valid(sample_valid),
    .diff_bit(diff_bit), .sym_start(sym_start), .busy(busy),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    bit ss;
    bit d;
    bit chk_d;
  } smp_t;

  smp_t q[$];
  int   total = 0, bad = 0;
  bit   mon_on = 0, rst_edge = 0, idle_edge = 0, exp_sv = 0, exp_under = 0;
  bit   prev_m = 0, clr_at_end = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares against expectations set up before the previous edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rst_edge) begin
        chk("rst_phase", phase_idx, 0);
        chk("rst_diff", diff_bit, 0);
        chk("rst_sym_start", sym_start, 0);
      end else if (idle_edge) begin
        chk("idle_phase", phase_idx, 0);
        chk("idle_sym_start", sym_start, 0);
      end
      chk("sample_valid", sample_valid, exp_sv);
      if (sample_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_sample", 1, 0);
        end else begin
          smp_t e;
          e = q.pop_front();
          chk("phase_idx", phase_idx, e.ph);
          chk("sym_start", sym_start, e.ss);
          if (e.chk_d) chk("diff_bit", diff_bit, e.d);
        end
      end
      chk("busy", busy, q.size() != 0);
      chk("underrun", underrun, exp_under);
    end
  end

  // One clock of stimulus plus the reference model of what that edge does.
  task automatic step(input bit r, input bit e, input bit bv, input bit b,
                      input bit c, output bit xf);
    bit er, d;
    @(negedge clk);
    #2;
    rst = r; en = e; bit_valid = bv; bit_in = b;
    clr_underrun = c | (clr_at_end && q.size() == 1 && e);
    #1;
    xf = 0;
    if (r) begin
      q.delete();
      prev_m = 0; exp_under = 0; exp_sv = 0;
      rst_edge = 1; idle_edge = 0;
    end else begin
      rst_edge = 0;
      // Ready in IDLE, or when the final sample of a symbol goes out now.
      er = (q.size() == 0) || (q.size() == 1 && e);
      chk("bit_ready", bit_ready, er);
      xf = bv && er;
      exp_sv = (q.size() > 0) && e;
      idle_edge = (q.size() == 0);
      if (q.size() == 1 && e && !xf) exp_under = 1;
      else if (clr_underrun) exp_under = 0;
      if (xf) begin
        d = b ^ prev_m;
        prev_m = d;
        for (int i = 0; i < SYM_LEN; i++)
          q.push_back('{ph: (i % SAMPLES_PER_CYC + (d ? PI_OFFSET : 0)) % SAMPLES_PER_CYC,
                        ss: (i == 0), d: d, chk_d: (i != SYM_LEN - 1)});
      end
    end
  endtask

  task automatic drain(input string name, input int period);
    bit xf;
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      step(0, (n % period) == 0, 0, 0, 0, xf);
      n++;
    end
    if (q.size() != 0) begin
      chk({name, "_drain_timeout"}, q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    bit xf;
    bit bits [3];
    int k, n;
    rst = 1; en = 0; bit_valid = 1; bit_in = 0; clr_underrun = 0;

    // Reset held 3 cycles with a valid bit presented.
    step(1, 0, 1, 0, 0, xf);
    mon_on = 1;
    repeat (2) step(1, 0, 1, 0, 0, xf);
    step(0, 0, 0, 0, 0, xf);

    // Single bit 1, en always high, then underrun.
    step(0, 1, 1, 1, 0, xf);
    drain("single", 1);
    step(0, 1, 0, 0, 0, xf);
    step(0, 1, 0, 0, 1, xf);

    // Back-to-back bits 1,1,0 held valid.
    bits[0] = 1; bits[1] = 1; bits[2] = 0;
    k = 0; n = 0;
    while (k < 3 && n < 1000) begin
      step(0, 1, 1, bits[k], 0, xf);
      if (xf) k++;
      n++;
    end
    chk("b2b_accepts", k, 3);
    drain("b2b", 1);
    step(0, 1, 0, 0, 1, xf);

    // en pulsed 1-of-3 cycles.
    step(0, 1, 1, 1'($urandom_range(0, 1)), 0, xf);
    drain("en_third", 3);
    step(0, 0, 0, 0, 1, xf);

    // Reset at sample 37 of a symbol, then bit 1 from clean history.
    step(0, 1, 1, 1'($urandom_range(0, 1)), 0, xf);
    repeat (37) step(0, 1, 0, 0, 0, xf);
    step(1, 1, 0, 0, 0, xf);
    step(0, 1, 1, 1, 0, xf);
    drain("post_rst", 1);

    // Underrun set while clr_underrun is high, then cleared.
    step(0, 1, 0, 0, 1, xf);
    step(0, 1, 1, 0, 0, xf);
    clr_at_end = 1;
    drain("clr_race", 1);
    clr_at_end = 0;
    step(0, 1, 0, 0, 0, xf);
    step(0, 1, 0, 0, 1, xf);

    // Random traffic.
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 699) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, xf);
    drain("final", 1);
    step(0, 0, 0, 0, 0, xf);
    step(0, 0, 0, 0, 0, xf);
    mon_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
